cache_ctrl_fsm: RTL and testbench
=================================

# cache_ctrl_fsm

Sequential, parametrised set-associative cache controller, write-back/write-allocate, sitting between the pipeline's memory stage and the line-granular main-memory port. Owns the tag, valid, dirty and per-set FIFO replacement state. Sequences hit, writeback, refill and whole-cache flush. Drives the separate data array through way/index/fill strobes.

## Interface
Parameters:
- NUM_WAYS, 2, associativity (power of two, ≥1)
- SET_BITS, 3, log2(number of sets)
- OFFSET_BITS, 4, log2(line bytes)
- WAY_BITS, 1, log2(NUM_WAYS) (min 1)
- TAG_BITS (localparam), 32-SET_BITS-OFFSET_BITS

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  access request
- req_ready  out  1  controller accepts request
- req_addr  in  32  byte address
- req_write  in  1  1 = store
- resp_valid  out  1  one-cycle completion pulse
- resp_hit  out  1  1 = hit, 0 = serviced miss
- resp_way  out  WAY_BITS  way holding the line
- flush  in  1  write back all dirty lines (level, sampled in IDLE)
- flush_done  out  1  one-cycle pulse at flush end
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_write  out  1  1 = writeback, 0 = line read
- mem_req_addr  out  32  line address, low OFFSET_BITS zero
- mem_resp_valid  in  1  read line returned
- data_index  out  SET_BITS  data-array set select
- data_way  out  WAY_BITS  data-array way select
- data_fill  out  1  write returned line into data array this cycle
- hit_count, miss_count, wb_count  out  32 each  performance counters

## Operation
- Address split: tag = addr[31:SET_BITS+OFFSET_BITS], index = addr[SET_BITS+OFFSET_BITS-1:OFFSET_BITS].
- States: IDLE, LOOKUP, WB_REQ, RD_REQ, RD_WAIT, RESP, FLUSH_SCAN, FLUSH_WB.
- IDLE: req_ready=1 unless flush=1. flush has priority and moves to FLUSH_SCAN. Otherwise req_valid latches addr/write and moves to LOOKUP.
- LOOKUP: hit = valid & tag match in any way.
  - Hit: store sets dirty. Go to RESP with resp_hit=1.
  - Miss victim: lowest-index invalid way, else fifo_ptr[index]. Victim valid & dirty → WB_REQ, else RD_REQ.
- WB_REQ: mem_req_write=1, addr={victim tag, index, 0}. On mem_req_ready → RD_REQ.
- RD_REQ: read, addr={req tag, index, 0}. On mem_req_ready → RD_WAIT.
- RD_WAIT: on mem_resp_valid:
  - data_fill=1 for that cycle.
  - Victim updated: tag written, valid=1, dirty=req_write.
  - fifo_ptr[index] increments (mod NUM_WAYS) only when the victim came from the pointer.
  - Go to RESP with resp_hit=0.
- RESP: resp_valid=1 for one cycle, resp_way = serviced way → IDLE. No response backpressure.
- FLUSH_SCAN: walks entries set-major, way-minor, one per cycle. A dirty & valid entry → FLUSH_WB.
- FLUSH_WB: writeback request. On accept, clears dirty (valid kept) and resumes scan.
- After the last entry: flush_done pulse, → IDLE.
- data_index/data_way reflect the current request or victim in all non-IDLE states.
- mem_resp_valid outside RD_WAIT is ignored. mem_req_ready is ignored while mem_req_valid=0.

## Timing
- Reset: state IDLE, all valid/dirty/fifo_ptr 0, all outputs 0 except req_ready=1. Counters 0.
- Reset mid-operation aborts immediately: mem_req_valid drops asynchronously and the transaction is lost.
- Hit latency: request accepted at edge T → LOOKUP cycle T+1 → resp_valid in cycle T+2.
- Clean miss: minimum 4 cycles after accept plus memory wait.
- Dirty miss: clean-miss latency + 1 cycle + writeback accept wait.
- mem_req_valid/addr/write are stable from assertion until the accepting edge.
- Flush of an all-clean cache: flush_done exactly NUM_WAYS·2^SET_BITS+1 cycles after entry.

## Configuration
- CACHE_CTRL_PERF_EN defined:
  - hit_count +1 per hit RESP; miss_count +1 per miss RESP; wb_count +1 per accepted writeback, including flush.
  - All counters are 32-bit wrapping, reset to 0.
- Undefined: counter logic absent, ports driven 0.

## Test plan
Defaults: NUM_WAYS=2, SET_BITS=3, OFFSET_BITS=4.
- Cold read of 0x00000040, mem_resp_valid 3 cycles after read accept:
  - Expect mem_req read at 0x40, data_fill with index 4, way 0.
  - resp_valid with hit=0, way=0.
  - Then read 0x44 → resp_valid 2 cycles after accept, hit=1, way=0, no mem_req.
- Store 0x40 (hit, dirty), read 0xC0 (fills way 1), read 0x140:
  - Expect writeback to 0x40, then read 0x140 into way 0.
  - fifo_ptr[4]=1 afterwards.
- Hold mem_req_ready=0 for 5 cycles during WB_REQ → mem_req_valid/addr/write unchanged all 5 cycles. Single writeback issued.
- Dirty lines at 0x40 and 0x1C0, then assert flush:
  - Exactly two writes, to 0x40 and 0x1C0, in scan order.
  - flush_done one pulse; req_ready low throughout.
  - Later read 0x40 hits.
- Assert reset_n=0 during RD_WAIT → all outputs at reset values same cycle. Subsequent read of 0x40 misses.
- With CACHE_CTRL_PERF_EN, run the second scenario → hit_count=1, miss_count=2, wb_count=1. Without the macro all three read 0.

Source files
------------

// File: rtl/cache_ctrl_fsm.sv
// Set-associative write-back/write-allocate cache controller: tags, valid/dirty, per-set FIFO replacement, flush.
// Define CACHE_CTRL_PERF_EN to build the hit/miss/writeback counters; otherwise the counter ports read 0.
module cache_ctrl_fsm #(
  parameter int unsigned NUM_WAYS    = 2,
  parameter int unsigned SET_BITS    = 3,
  parameter int unsigned OFFSET_BITS = 4,
  parameter int unsigned WAY_BITS    = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_addr,
  input  logic                req_write,
  output logic                resp_valid,
  output logic                resp_hit,
  output logic [WAY_BITS-1:0] resp_way,
  input  logic                flush,
  output logic                flush_done,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_write,
  output logic [31:0]         mem_req_addr,
  input  logic                mem_resp_valid,
  output logic [SET_BITS-1:0] data_index,
  output logic [WAY_BITS-1:0] data_way,
  output logic                data_fill,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count,
  output logic [31:0]         wb_count
);

  localparam int unsigned TAG_BITS = 32 - SET_BITS - OFFSET_BITS;
  localparam int unsigned NUM_SETS = 1 << SET_BITS;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LOOKUP     = 3'd1;
  localparam logic [2:0] S_WB_REQ     = 3'd2;
  localparam logic [2:0] S_RD_REQ     = 3'd3;
  localparam logic [2:0] S_RD_WAIT    = 3'd4;
  localparam logic [2:0] S_RESP       = 3'd5;
  localparam logic [2:0] S_FLUSH_SCAN = 3'd6;
  localparam logic [2:0] S_FLUSH_WB   = 3'd7;

  logic [2:0]          state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic                write_q, write_d;
  logic [WAY_BITS-1:0] way_q, way_d;
  logic                from_ptr_q, from_ptr_d;
  logic                resp_hit_q, resp_hit_d;
  logic [SET_BITS-1:0] scan_set_q, scan_set_d;
  logic [WAY_BITS-1:0] scan_way_q, scan_way_d;
  logic                flush_done_q, flush_done_d;

  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_d [NUM_SETS];
  logic [TAG_BITS-1:0] tag_q   [NUM_SETS][NUM_WAYS];
  logic [TAG_BITS-1:0] tag_d   [NUM_SETS][NUM_WAYS];
  logic [WAY_BITS-1:0] fifo_q  [NUM_SETS];
  logic [WAY_BITS-1:0] fifo_d  [NUM_SETS];

  logic [SET_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0] req_tag;
  logic                hit, inv_found, wb_acc, scan_adv, scan_last;
  logic [WAY_BITS-1:0] hit_way, inv_way, victim_way, fifo_next;
  logic                unused_offset;

  assign req_idx       = addr_q[SET_BITS+OFFSET_BITS-1:OFFSET_BITS];
  assign req_tag       = addr_q[31:SET_BITS+OFFSET_BITS];
  assign unused_offset = ^addr_q[OFFSET_BITS-1:0];
  assign scan_last     = (scan_set_q == SET_BITS'(NUM_SETS - 1)) &&
                         (scan_way_q == WAY_BITS'(NUM_WAYS - 1));
  assign fifo_next     = WAY_BITS'((32'(fifo_q[req_idx]) + 32'd1) % NUM_WAYS);

  // Tag match and lowest-index invalid way for the latched request's set
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit && valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
      if (!inv_found && !valid_q[req_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_BITS'(w);
      end
    end
  end

  assign victim_way = inv_found ? inv_way : fifo_q[req_idx];

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    write_d      = write_q;
    way_d        = way_q;
    from_ptr_d   = from_ptr_q;
    resp_hit_d   = resp_hit_q;
    scan_set_d   = scan_set_q;
    scan_way_d   = scan_way_q;
    flush_done_d = 1'b0;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    fifo_d       = fifo_q;
    wb_acc       = 1'b0;
    scan_adv     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          state_d    = S_FLUSH_SCAN;
          scan_set_d = '0;
          scan_way_d = '0;
        end else if (req_valid) begin
          addr_d  = req_addr;
          write_d = req_write;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          way_d      = hit_way;
          resp_hit_d = 1'b1;
          if (write_q) dirty_d[req_idx][hit_way] = 1'b1;
          state_d = S_RESP;
        end else begin
          way_d      = victim_way;
          from_ptr_d = !inv_found;
          resp_hit_d = 1'b0;
          state_d    = (valid_q[req_idx][victim_way] && dirty_q[req_idx][victim_way]) ?
                       S_WB_REQ : S_RD_REQ;
        end
      end
      S_WB_REQ: begin
        if (mem_req_ready) begin
          wb_acc  = 1'b1;
          state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (mem_req_ready) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (mem_resp_valid) begin
          tag_d[req_idx][way_q]   = req_tag;
          valid_d[req_idx][way_q] = 1'b1;
          dirty_d[req_idx][way_q] = write_q;
          if (from_ptr_q) fifo_d[req_idx] = fifo_next;
          state_d = S_RESP;
        end
      end
      S_RESP: state_d = S_IDLE;
      S_FLUSH_SCAN: begin
        if (valid_q[scan_set_q][scan_way_q] && dirty_q[scan_set_q][scan_way_q]) state_d = S_FLUSH_WB;
        else scan_adv = 1'b1;
      end
      S_FLUSH_WB: begin
        if (mem_req_ready) begin
          wb_acc                            = 1'b1;
          dirty_d[scan_set_q][scan_way_q]   = 1'b0;
          scan_adv                          = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Set-major, way-minor walk; the last entry ends the flush
    if (scan_adv) begin
      if (scan_last) begin
        state_d      = S_IDLE;
        flush_done_d = 1'b1;
      end else begin
        state_d = S_FLUSH_SCAN;
        if (scan_way_q == WAY_BITS'(NUM_WAYS - 1)) begin
          scan_way_d = '0;
          scan_set_d = scan_set_q + SET_BITS'(1);
        end else begin
          scan_way_d = scan_way_q + WAY_BITS'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      write_q      <= 1'b0;
      way_q        <= '0;
      from_ptr_q   <= 1'b0;
      resp_hit_q   <= 1'b0;
      scan_set_q   <= '0;
      scan_way_q   <= '0;
      flush_done_q <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        fifo_q[s]  <= '0;
        for (int w = 0; w < NUM_WAYS; w++) tag_q[s][w] <= '0;
      end
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      way_q        <= way_d;
      from_ptr_q   <= from_ptr_d;
      resp_hit_q   <= resp_hit_d;
      scan_set_q   <= scan_set_d;
      scan_way_q   <= scan_way_d;
      flush_done_q <= flush_done_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      tag_q        <= tag_d;
      fifo_q       <= fifo_d;
    end
  end

  // Outputs decode the state register, so reset clears them immediately
  assign req_ready     = (state_q == S_IDLE) && !flush;
  assign resp_valid    = (state_q == S_RESP);
  assign resp_hit      = resp_valid && resp_hit_q;
  assign resp_way      = resp_valid ? way_q : '0;
  assign flush_done    = flush_done_q;
  assign mem_req_valid = (state_q == S_WB_REQ) || (state_q == S_RD_REQ) || (state_q == S_FLUSH_WB);
  assign mem_req_write = (state_q == S_WB_REQ) || (state_q == S_FLUSH_WB);
  assign data_fill     = (state_q == S_RD_WAIT) && mem_resp_valid;

  always_comb begin
    mem_req_addr = '0;
    data_index   = req_idx;
    data_way     = way_q;
    case (state_q)
      S_IDLE: begin
        data_index = '0;
        data_way   = '0;
      end
      S_LOOKUP:   data_way = hit ? hit_way : victim_way;
      S_WB_REQ:   mem_req_addr = {tag_q[req_idx][way_q], req_idx, {OFFSET_BITS{1'b0}}};
      S_RD_REQ:   mem_req_addr = {req_tag, req_idx, {OFFSET_BITS{1'b0}}};
      S_FLUSH_SCAN: begin
        data_index = scan_set_q;
        data_way   = scan_way_q;
      end
      S_FLUSH_WB: begin
        data_index   = scan_set_q;
        data_way     = scan_way_q;
        mem_req_addr = {tag_q[scan_set_q][scan_way_q], scan_set_q, {OFFSET_BITS{1'b0}}};
      end
      default: ;
    endcase
  end

`ifdef CACHE_CTRL_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, wb_cnt_q, wb_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    if (state_q == S_RESP) begin
      if (resp_hit_q) hit_cnt_d = hit_cnt_q + 32'd1;
      else            miss_cnt_d = miss_cnt_q + 32'd1;
    end
    if (wb_acc) wb_cnt_d = wb_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign wb_count   = wb_cnt_q;
`else
  logic unused_wb_acc;
  assign unused_wb_acc = wb_acc;
  assign hit_count     = '0;
  assign miss_count    = '0;
  assign wb_count      = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Bench for cache_ctrl_fsm: directed scenarios plus randomized traffic checked against an array-based cache model.
module tb_cache_ctrl_fsm;

  localparam int NW = 2;
  localparam int NS = 8;

  logic        clk, reset_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic        resp_valid, resp_hit;
  logic [0:0]  resp_way;
  logic        flush, flush_done;
  logic        mem_req_valid, mem_req_ready, mem_req_write, mem_resp_valid;
  logic [31:0] mem_req_addr;
  logic [2:0]  data_index;
  logic [0:0]  data_way;
  logic        data_fill;
  logic [31:0] hit_count, miss_count, wb_count;

  cache_ctrl_fsm #(.NUM_WAYS(2), .SET_BITS(3), .OFFSET_BITS(4), .WAY_BITS(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_write(req_write),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .flush(flush), .flush_done(flush_done),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
    .data_index(data_index), .data_way(data_way), .data_fill(data_fill),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference cache: per-set line table with a FIFO replacement pointer
  bit          mv [NS][NW];
  bit          md [NS][NW];
  logic [31:0] mt [NS][NW];
  int          mf [NS];
  int          eh, em, ewb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] line_addr(input logic [31:0] t, input int s);
    return (t << 7) | (32'(s) << 4);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      mf[s] = 0;
      for (int w = 0; w < NW; w++) begin
        mv[s][w] = 0;
        md[s][w] = 0;
        mt[s][w] = '0;
      end
    end
    eh = 0; em = 0; ewb = 0;
  endtask

  task automatic check_counters();
`ifdef CACHE_CTRL_PERF_EN
    check("hit_count", hit_count, 32'(eh));
    check("miss_count", miss_count, 32'(em));
    check("wb_count", wb_count, 32'(ewb));
`else
    check("hit_count", hit_count, 32'd0);
    check("miss_count", miss_count, 32'd0);
    check("wb_count", wb_count, 32'd0);
`endif
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_hit", 32'(resp_hit), 32'd0);
    check("rst_resp_way", 32'(resp_way), 32'd0);
    check("rst_flush_done", 32'(flush_done), 32'd0);
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_mem_req_write", 32'(mem_req_write), 32'd0);
    check("rst_mem_req_addr", mem_req_addr, 32'd0);
    check("rst_data_fill", 32'(data_fill), 32'd0);
    check("rst_data_index", 32'(data_index), 32'd0);
    check("rst_data_way", 32'(data_way), 32'd0);
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
    check("rst_wb_count", wb_count, 32'd0);
  endtask

  // One access or flush: the bench plays main memory, predicts every memory op and the exact latency
  task automatic run_txn(input bit is_flush, input logic [31:0] a, input bit wr, input int dly,
                         input bit rnd_dly, input int resp_dly, input bit abort);
    int          cyc, hold, target, resp_cnt, exp_lat, idx, way;
    bit          pend, rd_acc, done, hit, use_ptr;
    logic [31:0] tg;
    logic [32:0] cur;
    logic [32:0] ops[$];
    cyc = 0; hold = 0; target = 0; resp_cnt = -1; exp_lat = 0; way = 0;
    pend = 0; rd_acc = 0; done = 0; hit = 0; use_ptr = 0; cur = '0;
    idx = int'(a[6:4]);
    tg  = a >> 7;
    if (is_flush) begin
      for (int s = 0; s < NS; s++)
        for (int w = 0; w < NW; w++)
          if (mv[s][w] && md[s][w]) begin
            ops.push_back({1'b1, line_addr(mt[s][w], s)});
            md[s][w] = 0;
          end
      exp_lat = NS * NW + 1 + ops.size();
    end else begin
      for (int w = 0; w < NW; w++)
        if (!hit && mv[idx][w] && mt[idx][w] == tg) begin
          hit = 1;
          way = w;
        end
      if (hit) exp_lat = 2;
      else begin
        use_ptr = 1;
        way = mf[idx];
        for (int w = NW - 1; w >= 0; w--)
          if (!mv[idx][w]) begin
            way = w;
            use_ptr = 0;
          end
        if (mv[idx][way] && md[idx][way]) ops.push_back({1'b1, line_addr(mt[idx][way], idx)});
        ops.push_back({1'b0, line_addr(tg, idx)});
        exp_lat = 4 + resp_dly + ops.size() - 1;
      end
    end

    @(negedge clk);
    if (is_flush) flush = 1'b1;
    else begin
      check("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_addr  = a;
      req_write = wr;
    end

    while (!done) begin
      @(negedge clk);
      cyc++;
      req_valid      = 1'b0;
      req_addr       = $urandom;
      req_write      = 1'($urandom);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      if (cyc > 200) begin
        check("txn_timeout", 32'(cyc), 32'(exp_lat));
        flush = 1'b0;
        done  = 1;
      end else if (is_flush ? flush_done : resp_valid) begin
        check("latency", 32'(cyc), 32'(exp_lat));
        check("mem_ops_left", 32'(ops.size()), 32'd0);
        if (is_flush) begin
          check("req_ready_flush_end", 32'(req_ready), 32'd0);
          flush = 1'b0;
        end else begin
          check("resp_hit", 32'(resp_hit), 32'(hit));
          check("resp_way", 32'(resp_way), 32'(way));
        end
        done = 1;
      end else if (abort && rd_acc) begin
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        done = 1;
      end else begin
        if (is_flush) check("req_ready_flush", 32'(req_ready), 32'd0);
        if (resp_cnt == 0) begin
          mem_resp_valid = 1'b1;
          #1;
          check("fill_strobe", 32'(data_fill), 32'd1);
          check("fill_index", 32'(data_index), 32'(idx));
          check("fill_way", 32'(data_way), 32'(way));
          resp_cnt = -1;
        end else if (resp_cnt > 0) begin
          resp_cnt--;
        end else if (!rd_acc && $urandom_range(0, 3) == 0) begin
          mem_resp_valid = 1'b1;
          #1;
          check("fill_spurious", 32'(data_fill), 32'd0);
        end
        if (mem_req_valid) begin
          if (!pend) begin
            if (ops.size() == 0) check("mem_req_unexpected", 32'(mem_req_valid), 32'd0);
            else begin
              cur     = ops.pop_front();
              pend    = 1;
              hold    = 0;
              target  = rnd_dly ? int'($urandom_range(0, dly)) : dly;
              exp_lat += target;
              check("mem_req_write", 32'(mem_req_write), 32'(cur[32]));
              check("mem_req_addr", mem_req_addr, cur[31:0]);
            end
          end else begin
            hold++;
            check("mem_req_write_hold", 32'(mem_req_write), 32'(cur[32]));
            check("mem_req_addr_hold", mem_req_addr, cur[31:0]);
          end
          if (pend && hold == target) begin
            mem_req_ready = 1'b1;
            pend = 0;
            if (cur[32]) ewb++;
            else begin
              rd_acc   = 1;
              resp_cnt = resp_dly;
            end
          end
        end else begin
          if (pend) begin
            check("mem_req_dropped", 32'(mem_req_valid), 32'd1);
            pend = 0;
          end
          mem_req_ready = 1'($urandom);
        end
      end
    end

    if (!abort || !rd_acc) begin
      @(negedge clk);
      check("resp_one_cycle", 32'(resp_valid), 32'd0);
      check("flush_done_one_cycle", 32'(flush_done), 32'd0);
      check("req_ready_back", 32'(req_ready), 32'd1);
      if (!is_flush) begin
        if (hit) begin
          eh++;
          if (wr) md[idx][way] = 1;
        end else begin
          mt[idx][way] = tg;
          mv[idx][way] = 1;
          md[idx][way] = wr;
          if (use_ptr) mf[idx] = (mf[idx] + 1) % NW;
          em++;
        end
      end
    end
  endtask

  logic [31:0] ra;

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
    flush = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    model_reset();
    #1;
    check_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Cold read, then a hit in the same line
    run_txn(0, 32'h40, 0, 0, 0, 2, 0);
    run_txn(0, 32'h44, 0, 0, 0, 0, 0);
    // Store hit, fill way 1, then a dirty eviction of way 0
    run_txn(0, 32'h40, 1, 0, 0, 0, 0);
    run_txn(0, 32'hC0, 0, 1, 0, 1, 0);
    run_txn(0, 32'h140, 0, 0, 0, 0, 0);
    check_counters();
    // Writeback held off for five cycles
    run_txn(0, 32'hC0, 1, 0, 0, 0, 0);
    run_txn(0, 32'h240, 0, 5, 0, 0, 0);
    // Two dirty lines, flush, then a hit on a flushed line and a clean-cache flush
    run_txn(0, 32'h40, 1, 0, 0, 0, 0);
    run_txn(0, 32'h1C0, 1, 0, 0, 1, 0);
    run_txn(1, 32'h0, 0, 3, 1, 0, 0);
    run_txn(0, 32'h40, 0, 0, 0, 0, 0);
    run_txn(1, 32'h0, 0, 0, 0, 0, 0);
    check_counters();

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 11) == 0) run_txn(1, 32'h0, 0, 3, 1, 0, 0);
      else begin
        ra = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 4) |
             32'($urandom_range(0, 15));
        run_txn(0, ra, 1'($urandom), 3, 1, int'($urandom_range(0, 3)), 0);
      end
    end
    check_counters();

    // Reset while waiting for a line, then the cache must be cold again
    run_txn(0, 32'h340, 0, 1, 0, 5, 1);
    run_txn(0, 32'h40, 0, 0, 0, 1, 0);
    check_counters();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
